// File: rtl/cache_refill_engine_if.sv
// ============================================================================
// Module      : cache_refill_engine_if
// Description : Miss input, memory req/ack bus and L1 write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_refill_engine_if;
    logic       miss;
    logic [7:0] address;
    logic       flush;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       write_enable_L1;
    logic [2:0] write_select;
    logic [7:0] write_data_L1;
    logic [5:0] write_data_TA;
    logic       busy;
    logic       fill_done;
    logic       fill_err;

    modport master (
        input  miss, address, flush, mem_ack, mem_data,
        output mem_req, mem_addr, write_enable_L1, write_select,
               write_data_L1, write_data_TA, busy, fill_done, fill_err
    );

    modport slave (
        output miss, address, flush, mem_ack, mem_data,
        input  mem_req, mem_addr, write_enable_L1, write_select,
               write_data_L1, write_data_TA, busy, fill_done, fill_err
    );
endinterface

`default_nettype wire

// File: rtl/cache_refill_engine.sv
// ============================================================================
// Module      : cache_refill_engine
// Description : Refills the 8-entry fully associative L1 from main memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_refill_engine #(
    parameter int TIMEOUT = 15
) (
    input  logic                          CC_clk,
    input  logic                          rst,
    cache_refill_engine_if.master         bus
);

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_addr;
    logic [7:0] r_cnt;
    logic [7:0] r_valid;
    logic [2:0] r_rr_ptr;
    logic       r_from_rr;

    logic       r_mem_req;
    logic [7:0] r_mem_addr;
    logic       r_we;
    logic [2:0] r_sel;
    logic [7:0] r_wdata;
    logic [5:0] r_wta;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic [2:0] w_victim;
    logic       w_use_rr;

    // Lowest-index invalid entry first; round-robin only once the array is full.
    always_comb begin
        w_victim = r_rr_ptr;
        w_use_rr = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_victim = 3'(i);
                w_use_rr = 1'b0;
            end
        end
    end

    always_ff @(posedge CC_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= 8'd0;
            r_cnt      <= 8'd0;
            r_valid    <= 8'd0;
            r_rr_ptr   <= 3'd0;
            r_from_rr  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 8'd0;
            r_we       <= 1'b0;
            r_sel      <= 3'd0;
            r_wdata    <= 8'd0;
            r_wta      <= 6'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= 8'd0;
            r_we       <= 1'b0;
            r_sel      <= 3'd0;
            r_wdata    <= 8'd0;
            r_wta      <= 6'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.flush) begin
                        r_valid  <= 8'd0;
                        r_rr_ptr <= 3'd0;
                    end else if (bus.miss) begin
                        r_addr     <= bus.address;
                        r_cnt      <= 8'd0;
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= bus.address;
                        r_busy     <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (bus.mem_ack) begin
                        // Victim is frozen here; valid/rr_ptr cannot change before WRITE.
                        r_state   <= S_WRITE;
                        r_we      <= 1'b1;
                        r_sel     <= w_victim;
                        r_from_rr <= w_use_rr;
                        r_wdata   <= bus.mem_data;
                        r_wta     <= r_addr[5:0];
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + 8'd1;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_addr;
                    end
                end

                S_WRITE: begin
                    r_valid[r_sel] <= 1'b1;
                    if (r_from_rr) begin
                        r_rr_ptr <= r_rr_ptr + 3'd1;
                    end
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req         = r_mem_req;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.write_enable_L1 = r_we;
    assign bus.write_select    = r_sel;
    assign bus.write_data_L1   = r_wdata;
    assign bus.write_data_TA   = r_wta;
    assign bus.busy            = r_busy;
    assign bus.fill_done       = r_done;
    assign bus.fill_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_engine.sv
// ============================================================================
// Module      : tb_cache_refill_engine
// Description : Directed, table-driven bench for cache_refill_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_refill_engine;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    cache_refill_engine_if bus();

    cache_refill_engine #(.TIMEOUT(15)) dut (
        .CC_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         dly;
        logic [2:0] sel;
    } fill_t;

    fill_t vec [25];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic do_fill(input logic [7:0] a, input logic [7:0] d, input int dly,
                           input logic [2:0] esel, input bit toggle, input bit hold,
                           input string tag);
        bus.miss    = 1'b1;
        bus.address = a;
        tick();
        if (!hold) bus.miss = 1'b0;
        chk({tag, " req"},   bus.mem_req, 1);
        chk({tag, " maddr"}, bus.mem_addr, a);
        chk({tag, " busy"},  bus.busy, 1);
        for (int k = 0; k < dly; k++) begin
            if (toggle) begin
                bus.address = ~a;
                bus.miss    = k[0];
                bus.flush   = 1'b1;
            end
            tick();
            chk({tag, " req hold"},   bus.mem_req, 1);
            chk({tag, " maddr hold"}, bus.mem_addr, a);
        end
        if (toggle) begin
            bus.miss  = 1'b0;
            bus.flush = 1'b0;
        end
        bus.mem_ack  = 1'b1;
        bus.mem_data = d;
        tick();
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
        chk({tag, " we"},      bus.write_enable_L1, 1);
        chk({tag, " sel"},     bus.write_select, esel);
        chk({tag, " L1"},      bus.write_data_L1, d);
        chk({tag, " TA"},      bus.write_data_TA, a[5:0]);
        chk({tag, " req off"}, bus.mem_req, 0);
        tick();
        chk({tag, " we off"},  bus.write_enable_L1, 0);
        chk({tag, " done"},    bus.fill_done, 1);
        chk({tag, " busy dn"}, bus.busy, 1);
        tick();
        chk({tag, " idle"},    bus.busy, 0);
        chk({tag, " done off"}, bus.fill_done, 0);
        chk({tag, " idle req"}, bus.mem_req, 0);
    endtask

    initial begin
        int  n_req;
        bit  we_seen;

        n_tests = 0;
        n_fail  = 0;
        rst          = 1'b1;
        bus.miss     = 1'b0;
        bus.address  = 8'h00;
        bus.flush    = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;

        // Fill i selects entry i mod 8: 0..7 while filling, then round-robin from 0.
        for (int i = 0; i < 25; i++) begin
            vec[i].addr = 8'(8'h68 + i * 7);
            vec[i].data = 8'(8'h5A ^ (i * 13));
            vec[i].dly  = i % 4;
            vec[i].sel  = 3'(i % 8);
        end
        vec[0].dly = 3;

        tick();
        tick();
        chk("rst req",   bus.mem_req, 0);
        chk("rst maddr", bus.mem_addr, 0);
        chk("rst we",    bus.write_enable_L1, 0);
        chk("rst sel",   bus.write_select, 0);
        chk("rst L1",    bus.write_data_L1, 0);
        chk("rst TA",    bus.write_data_TA, 0);
        chk("rst busy",  bus.busy, 0);
        chk("rst done",  bus.fill_done, 0);
        chk("rst err",   bus.fill_err, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 25; i++) begin
            do_fill(vec[i].addr, vec[i].data, vec[i].dly, vec[i].sel, 1'b0, 1'b0,
                    $sformatf("fill%0d", i));
        end

        // Timeout: rr_ptr is 1 here and must stay 1.
        bus.miss    = 1'b1;
        bus.address = 8'hC3;
        tick();
        bus.miss = 1'b0;
        n_req   = 0;
        we_seen = 1'b0;
        while (bus.mem_req && n_req < 40) begin
            n_req++;
            we_seen = we_seen | bus.write_enable_L1;
            tick();
        end
        chk("tmo req cycles", n_req, 15);
        chk("tmo err",        bus.fill_err, 1);
        chk("tmo no we",      we_seen | bus.write_enable_L1, 0);
        tick();
        chk("tmo err off",    bus.fill_err, 0);
        chk("tmo idle",       bus.busy, 0);
        do_fill(8'h11, 8'hA5, 1, 3'd1, 1'b0, 1'b0, "post tmo");

        // Inputs toggled while busy, including flush during REQ.
        do_fill(8'h9C, 8'h3C, 3, 3'd2, 1'b1, 1'b0, "toggle");
        do_fill(8'h21, 8'h77, 0, 3'd3, 1'b0, 1'b0, "flush ignored");

        // Miss held across DONE: one IDLE cycle, then exactly one new fill.
        do_fill(8'h44, 8'h12, 1, 3'd4, 1'b0, 1'b1, "hold");
        do_fill(8'h44, 8'h13, 0, 3'd5, 1'b0, 1'b0, "hold refill");
        tick();
        chk("hold no extra", bus.busy, 0);

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush busy", bus.busy, 0);
        do_fill(8'h55, 8'hEE, 2, 3'd0, 1'b0, 1'b0, "after flush");

        // Reset during REQ.
        bus.miss    = 1'b1;
        bus.address = 8'h33;
        tick();
        bus.miss = 1'b0;
        chk("rstreq req", bus.mem_req, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstreq req off", bus.mem_req, 0);
        chk("rstreq busy",    bus.busy, 0);
        chk("rstreq we",      bus.write_enable_L1, 0);
        tick();
        chk("rstreq we2",     bus.write_enable_L1, 0);
        chk("rstreq done",    bus.fill_done, 0);
        do_fill(8'h66, 8'h01, 0, 3'd0, 1'b0, 1'b0, "rstreq next");
        do_fill(8'h67, 8'h02, 1, 3'd1, 1'b0, 1'b0, "rstreq next2");

        // Reset during WRITE.
        bus.miss    = 1'b1;
        bus.address = 8'h7E;
        tick();
        bus.miss     = 1'b0;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'hBB;
        tick();
        bus.mem_ack = 1'b0;
        chk("rstwr we",  bus.write_enable_L1, 1);
        chk("rstwr sel", bus.write_select, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstwr we off", bus.write_enable_L1, 0);
        chk("rstwr done",   bus.fill_done, 0);
        chk("rstwr busy",   bus.busy, 0);
        do_fill(8'h08, 8'h80, 1, 3'd0, 1'b0, 1'b0, "rstwr next");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
